// File: rtl/instr_fetch_pkg.sv
// instr_fetch shared types: bus widths, FSM states, prefetch entry layout.
// Imported by the fetch interface, FIFO and top.
package instr_fetch_pkg;

   localparam int ADR_WIDTH   = 16;
   localparam int DAT_WIDTH   = 64;
   localparam int WORD_BYTES  = DAT_WIDTH / 8;
   localparam int ENTRY_WIDTH = DAT_WIDTH + ADR_WIDTH + 1;

   typedef enum logic [1:0] {
      FETCH_IDLE    = 2'd0,
      FETCH_REQ     = 2'd1,
      FETCH_RELEASE = 2'd2,
      FETCH_HALT    = 2'd3
   } fetch_state_e;

   typedef struct packed {
      logic [DAT_WIDTH-1:0] dat;
      logic [ADR_WIDTH-1:0] pc;
      logic                 fault;
   } fetch_entry_t;

   function automatic logic [ADR_WIDTH-1:0] align_pc(
      input logic [ADR_WIDTH-1:0] pc
   );
      return pc & ~ADR_WIDTH'(WORD_BYTES - 1);
   endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Wishbone fetch port and decode-side instruction handshake.
// Master modports belong to instr_fetch.
interface fetch_wb_if;
   import instr_fetch_pkg::*;

   logic                 cyc;
   logic                 stb;
   logic                 we;
   logic [ADR_WIDTH-1:0] adr;
   logic [DAT_WIDTH-1:0] dat;
   logic                 ack;
   logic                 err;

   modport master (
      output cyc, stb, we, adr,
      input  dat, ack, err
   );

   modport slave (
      input  cyc, stb, we, adr,
      output dat, ack, err
   );
endinterface

interface fetch_ins_if;
   import instr_fetch_pkg::*;

   logic                 valid;
   logic                 ready;
   logic [DAT_WIDTH-1:0] ins;
   logic [ADR_WIDTH-1:0] pc;
   logic                 fault;

   modport master (
      output valid, ins, pc, fault,
      input  ready
   );

   modport slave (
      input  valid, ins, pc, fault,
      output ready
   );
endinterface

// File: rtl/instr_fetch_fifo.sv
// Prefetch FIFO with flush and a registered head entry.
// Head is zero whenever the FIFO is empty.
module instr_fetch_fifo
   import instr_fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = PW + 1
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         flush_i,
   input  logic         push_i,
   input  fetch_entry_t push_entry_i,
   input  logic         pop_i,
   output logic [CW-1:0] count_o,
   output logic         head_valid_o,
   output fetch_entry_t head_o
);

   logic [ENTRY_WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0] cnt_q, cnt_d, left;
   logic          valid_q, valid_d, do_pop;
   fetch_entry_t  head_q, head_d;

   always_comb begin
      do_pop  = pop_i & valid_q & ~flush_i;
      left    = cnt_q - CW'(do_pop);
      rd_d    = rd_q + PW'(do_pop);
      wr_d    = wr_q + PW'(push_i);
      cnt_d   = left + CW'(push_i);
      if (flush_i) begin
         rd_d  = '0;
         wr_d  = '0;
         cnt_d = '0;
      end
      valid_d = (cnt_d != '0);
      head_d  = '0;
      // A push into an otherwise-empty FIFO bypasses the array.
      if (valid_d) begin
         if (push_i && left == '0)
            head_d = push_entry_i;
         else
            head_d = fetch_entry_t'(mem_q[rd_d]);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i && !flush_i)
         mem_q[wr_q] <= push_entry_i;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         rd_q    <= '0;
         wr_q    <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         head_q  <= '0;
      end else begin
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         head_q  <= head_d;
      end
   end

   assign count_o      = cnt_q;
   assign head_valid_o = valid_q;
   assign head_o       = head_q;

endmodule

// File: rtl/instr_fetch.sv
// Wishbone instruction fetch master feeding a prefetch FIFO.
// Bus errors become fault entries; redirect flushes and restarts.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [ADR_WIDTH-1:0] RESET_VECTOR = '0,
   parameter int DEPTH = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   fetch_wb_if.master           fetch,
   fetch_ins_if.master          ins,
   input  logic                 redirect_i,
   input  logic [ADR_WIDTH-1:0] redirect_pc_i
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_e         state_q, state_d;
   logic [ADR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADR_WIDTH-1:0] req_adr_q, req_adr_d;
   logic                 discard_q, discard_d;
   logic                 stb, push, issue, done;
   fetch_entry_t         push_entry, head;
   logic [CW-1:0]        count;

   assign issue = (count < CW'(DEPTH)) & ~redirect_i;
   assign done  = fetch.ack | fetch.err;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_adr_d  = req_adr_q;
      discard_d  = discard_q;
      stb        = 1'b0;
      push       = 1'b0;
      push_entry = '0;
      unique case (state_q)
         FETCH_IDLE: begin
            if (issue) begin
               stb       = 1'b1;
               req_adr_d = fetch_pc_q;
               state_d   = FETCH_REQ;
            end
         end
         FETCH_REQ: begin
            stb = 1'b1;
            if (done) begin
               discard_d = 1'b0;
               state_d   = FETCH_RELEASE;
               if (!discard_q && !redirect_i) begin
                  push             = 1'b1;
                  push_entry.pc    = req_adr_q;
                  push_entry.fault = ~fetch.ack;
                  if (fetch.ack) begin
                     push_entry.dat = fetch.dat;
                     fetch_pc_d = req_adr_q + ADR_WIDTH'(WORD_BYTES);
                  end else begin
                     state_d = FETCH_HALT;
                  end
               end
            end else if (redirect_i) begin
               discard_d = 1'b1;
            end
         end
         FETCH_RELEASE: state_d = FETCH_IDLE;
         FETCH_HALT: begin
            if (redirect_i)
               state_d = FETCH_IDLE;
         end
      endcase
      if (redirect_i)
         fetch_pc_d = align_pc(redirect_pc_i);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q    <= FETCH_IDLE;
         fetch_pc_q <= align_pc(RESET_VECTOR);
         req_adr_q  <= align_pc(RESET_VECTOR);
         discard_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_adr_q  <= req_adr_d;
         discard_q  <= discard_d;
      end
   end

   // Strobe drops during reset so a held slave ack cannot leak over.
   assign fetch.cyc = stb & rst_i;
   assign fetch.stb = stb & rst_i;
   assign fetch.we  = 1'b0;
   assign fetch.adr = (state_q == FETCH_REQ) ? req_adr_q : fetch_pc_q;

   instr_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .flush_i      (redirect_i),
      .push_i       (push),
      .push_entry_i (push_entry),
      .pop_i        (ins.ready),
      .count_o      (count),
      .head_valid_o (ins.valid),
      .head_o       (head)
   );

   assign ins.ins   = head.dat;
   assign ins.pc    = head.pc;
   assign ins.fault = head.fault;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage upstream of the ROM and any other Wishbone instruction slave. It is a Wishbone master that reads sequential 64-bit instruction words starting at a reset vector and buffers them in a small prefetch FIFO. It presents them to the decode stage over a valid/ready handshake, and restarts the fetch stream when the core redirects the program counter on a jump. Bus errors are turned into fault-tagged entries instead of being silently dropped.

## Interface
Parameters:
- RESET_VECTOR, 0, byte address of the first fetch after reset.
- DEPTH, 4, prefetch FIFO entries; power of two, ≥2.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-low reset (asserted when 0).
- fetch_cyc_o  out  1  Wishbone cycle.
- fetch_stb_o  out  1  Wishbone strobe.
- fetch_we_o  out  1  Wishbone write enable; constant 0.
- fetch_adr_o  out  `ADR_WIDTH  fetch byte address.
- fetch_dat_i  in  `DAT_WIDTH  read data.
- fetch_ack_i  in  1  slave acknowledge.
- fetch_err_i  in  1  slave error.
- ins_valid_o  out  1  FIFO head valid.
- ins_ready_i  in  1  decode accepts head.
- ins_o  out  `DAT_WIDTH  instruction word at head.
- ins_pc_o  out  `ADR_WIDTH  address of that word.
- ins_fault_o  out  1  head entry came from a bus error; ins_o is 0.
- redirect_i  in  1  one-cycle pulse that flushes the stream.
- redirect_pc_i  in  `ADR_WIDTH  new fetch address; low 3 bits ignored (forced 0).

## Operation
- fetch_pc holds the next fetch address. Each accepted word advances it by `DAT_WIDTH/8` (8). It wraps modulo 2^`ADR_WIDTH`.
- States: IDLE, REQ, RELEASE, HALT.
- IDLE: if the issue condition holds (count + 0 < DEPTH, no redirect this cycle), drive stb/cyc high with adr = fetch_pc and go to REQ.
- REQ: hold stb, cyc and adr stable until ack or err.
  - On ack: push {fetch_dat_i, adr, fault=0} and go to RELEASE.
  - On err: push {0, adr, fault=1} and go to HALT.
- RELEASE: stb and cyc low for exactly one cycle. This lets the slave leave its hold state, because slaves keep ack high for as long as stb is high. Then go to IDLE.
- HALT: stb low, no fetches. Leave only on redirect.
- Redirect:
  - Flushes the FIFO in the same cycle (count = 0 next cycle) and loads fetch_pc with redirect_pc_i.
  - If it arrives in REQ, the current request is still completed on the bus, but its ack/err data is discarded (the discard flag is set until ack/err). The FSM then goes through RELEASE and refetches from the new PC.
  - In IDLE, RELEASE or HALT, the next state is IDLE (RELEASE still takes its one low cycle first).
- FIFO: push on accepted ack/err, pop on ins_valid_o & ins_ready_i.
  - Push and pop in the same cycle are both legal at any occupancy.
  - Pop is ignored in a redirect cycle.
  - The issue condition guarantees a push never finds the FIFO full.
- Simultaneous redirect with ack in REQ: the ack is consumed and discarded, and the FIFO is flushed.

## Timing
- Reset values: cyc/stb 0, we 0, adr = RESET_VECTOR, ins_valid_o 0, ins_o 0, ins_pc_o 0, ins_fault_o 0, state IDLE, FIFO empty, discard 0.
- The first stb is asserted in the first cycle after reset is released (cycle 0).
- With a registered-ack slave (ack one cycle after stb):
  - ack arrives in cycle 1 and the entry is written at the end of cycle 1.
  - ins_valid_o goes high in cycle 2.
- Throughput is one word every 3 cycles (REQ, REQ-with-ack, RELEASE).
- FIFO outputs are registered, with no combinational path from fetch_dat_i to ins_o.
- Redirect in cycle N while IDLE: stb with adr = redirect_pc_i in cycle N+1.
- ins_ready_i has no combinational path to the bus outputs.

## Structure
- Shared package/header `fetch.v`: state encodings (`FETCH_IDLE`..`FETCH_HALT`) and the entry width (`DAT_WIDTH` + `ADR_WIDTH` + 1).
- `ADR_WIDTH` and `DAT_WIDTH` come from config.v; the port list uses the existing Wishbone master-port macro with prefix fetch_.
- One sub-module, `fetch_fifo`: synchronous FIFO of DEPTH entries with flush, push, pop, count, registered head.

## Test plan
- Reset with RESET_VECTOR=0, ROM model with 1-cycle ack, ins_ready_i=1 -> stb at cycle 0 with adr 0x0000. ins_valid_o at cycle 2 with ins_o=64'h0280401002000010, pc 0; next words at pc 0x0008 and 0x0010 every 3 cycles.
- ins_ready_i=0, DEPTH=4 -> exactly 4 fetches (adr 0x00–0x18), then stb stays low. Raising ready pops 4 in order and fetching resumes at 0x20.
- Redirect to 0x0078 while in REQ for 0x0010 -> 0x0010 completes on the bus and is discarded, and the FIFO is empty. The next stb has adr 0x0078 and the next valid word is 64'h02028c0000000000 with pc 0x0078.
- Slave asserts err on 0x0018 -> an entry with fault=1, ins_o=0, pc 0x0018 is pushed and there is no further stb. A redirect to 0 restarts fetching at 0x0000.
- fetch_pc=2^`ADR_WIDTH`-8 -> the next fetch adr is 0 (wrap).
- rst_i low for one cycle in the middle of REQ -> all outputs return to reset values on the next cycle and the FIFO is empty.
